branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline.
- Replaces the fixed predict-not-taken / resolve-in-ID flow with a direct-mapped branch target buffer plus one 2-bit saturating counter per entry.
- Lookup is combinational from PC in IF. Update is clocked from the ID-stage branch resolution.
- Also produces the mispredict flag and running statistics counters.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational from IF; training and statistics are clocked from ID.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             hit_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_next_pc_o,
  input  logic             upd_valid_i,
  input  logic [XLEN-1:0]  upd_pc_i,
  input  logic             upd_taken_i,
  input  logic [XLEN-1:0]  upd_target_i,
  input  logic             upd_pred_taken_i,
  input  logic [XLEN-1:0]  upd_pred_target_i,
  output logic             mispredict_o,
  input  logic             clear_stats_i,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two >= 2");
  end

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] ltag;
  logic [XLEN-1:0]  pc_plus4;

  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic             unused_bits;

  assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

  assign idx      = pc_i[IDX_W+1:2];
  assign ltag     = pc_i[IDX_W+2 +: TAG_W];
  assign pc_plus4 = pc_i + XLEN'(4);

  assign hit_o          = valid_q[idx] && (tag_q[idx] == ltag);
  assign pred_taken_o   = enable_i && hit_o && ctr_q[idx][1];
  assign pred_next_pc_o = pred_taken_o ? target_q[idx] : pc_plus4;

  assign uidx    = upd_pc_i[IDX_W+1:2];
  assign utag    = upd_pc_i[IDX_W+2 +: TAG_W];
  assign uhit    = valid_q[uidx] && (tag_q[uidx] == utag);
  assign ctr_cur = ctr_q[uidx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  assign mispredict_o = upd_valid_i &&
    ((upd_taken_i != upd_pred_taken_i) ||
     (upd_taken_i && upd_pred_taken_i &&
      (upd_target_i != upd_pred_target_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid_i) begin
      unique case (1'b1)
        uhit: begin
          ctr_q[uidx] <= ctr_nxt;
          if (upd_taken_i) target_q[uidx] <= upd_target_i;
        end
        (!uhit && upd_taken_i): begin
          valid_q[uidx]  <= 1'b1;
          tag_q[uidx]    <= utag;
          target_q[uidx] <= upd_target_i;
          ctr_q[uidx]    <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Counters saturate rather than wrap so long runs stay meaningful
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (clear_stats_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd_valid_i && branch_cnt_q != '1)
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (mispredict_o && mispred_cnt_q != '1)
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor.
// A behavioural table model predicts lookups, mispredicts and stats.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             enable_i;
  logic [XLEN-1:0]  pc_i;
  logic             hit_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_next_pc_o;
  logic             upd_valid_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic             upd_taken_i;
  logic [XLEN-1:0]  upd_target_i;
  logic             upd_pred_taken_i;
  logic [XLEN-1:0]  upd_pred_target_i;
  logic             mispredict_o;
  logic             clear_stats_i;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  int nchk = 0;
  int nerr = 0;

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .pc_i(pc_i), .hit_o(hit_o), .pred_taken_o(pred_taken_o),
    .pred_next_pc_o(pred_next_pc_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o(mispredict_o), .clear_stats_i(clear_stats_i),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: one record per slot, tag kept as the PC's upper part
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_bc;
  int          m_mc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int slot(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint ptag(logic [31:0] pc);
    return longint'(pc / (4 * ENTRIES));
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[slot(pc)] && m_tag[slot(pc)] == ptag(pc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  function automatic bit m_mispred();
    if (!upd_valid_i) return 0;
    if (upd_taken_i != upd_pred_taken_i) return 1;
    return upd_taken_i && upd_target_i != upd_pred_target_i;
  endfunction

  task automatic drive(bit en, logic [31:0] pc, bit uv,
                       logic [31:0] upc, bit ut, logic [31:0] utgt,
                       bit upt, logic [31:0] uptgt, bit clr);
    enable_i          = en;
    pc_i              = pc;
    upd_valid_i       = uv;
    upd_pc_i          = upc;
    upd_taken_i       = ut;
    upd_target_i      = utgt;
    upd_pred_taken_i  = upt;
    upd_pred_target_i = uptgt;
    clear_stats_i     = clr;
  endtask

  // Check lookup/mispredict, clock once, train model, check stats
  task automatic step();
    bit          eh, ept, emp;
    logic [31:0] enx;
    int          s;
    #1;
    eh  = m_hit(pc_i);
    ept = enable_i && eh && m_ctr[slot(pc_i)] >= 2;
    enx = ept ? m_tgt[slot(pc_i)] : pc_i + 32'd4;
    emp = m_mispred();
    chk("hit", 32'(hit_o), 32'(eh));
    chk("pred_taken", 32'(pred_taken_o), 32'(ept));
    chk("next_pc", pred_next_pc_o, enx);
    chk("mispredict", 32'(mispredict_o), 32'(emp));
    @(posedge clk_i);
    if (upd_valid_i) begin
      s = slot(upd_pc_i);
      if (m_hit(upd_pc_i)) begin
        if (upd_taken_i) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = upd_target_i;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (upd_taken_i) begin
        m_valid[s] = 1;
        m_tag[s]   = ptag(upd_pc_i);
        m_tgt[s]   = upd_target_i;
        m_ctr[s]   = 2;
      end
    end
    if (clear_stats_i) begin
      m_bc = 0;
      m_mc = 0;
    end else begin
      if (upd_valid_i && m_bc < CMAX) m_bc++;
      if (emp && m_mc < CMAX) m_mc++;
    end
    @(negedge clk_i);
    chk("branch_cnt", 32'(branch_cnt_o), 32'(m_bc));
    chk("mispred_cnt", 32'(mispred_cnt_o), 32'(m_mc));
  endtask

  task automatic look(bit en, logic [31:0] pc);
    drive(en, pc, 0, '0, 0, '0, 0, '0, 0);
  endtask

  initial begin
    logic [31:0] pc, upc, tg;
    model_reset();
    rst_i = 1'b0;
    look(1, 32'h100);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    #1;
    chk("rst_hit", 32'(hit_o), 32'd0);
    chk("rst_pt", 32'(pred_taken_o), 32'd0);
    chk("rst_next", pred_next_pc_o, 32'h104);
    chk("rst_bc", 32'(branch_cnt_o), 32'd0);
    chk("rst_mc", 32'(mispred_cnt_o), 32'd0);
    step();

    drive(1, 32'h100, 1, 32'h100, 1, 32'h40, 0, '0, 0);
    step();
    look(1, 32'h100);
    #1;
    chk("alloc_hit", 32'(hit_o), 32'd1);
    chk("alloc_next", pred_next_pc_o, 32'h40);
    chk("alloc_mc", 32'(mispred_cnt_o), 32'd1);
    step();

    repeat (3) begin
      drive(1, 32'h100, 1, 32'h100, 0, '0, 1, 32'h40, 0);
      step();
    end
    repeat (3) begin
      drive(1, 32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h40, 0);
      step();
    end
    look(0, 32'h100);
    #1;
    chk("static_pt", 32'(pred_taken_o), 32'd0);
    chk("static_next", pred_next_pc_o, 32'h104);
    step();

    drive(1, 32'h140, 1, 32'h140, 1, 32'h80, 0, '0, 0);
    #1;
    chk("same_cyc_hit", 32'(hit_o), 32'd0);
    step();
    look(1, 32'h100);
    step();
    look(1, 32'h140);
    #1;
    chk("evict_next", pred_next_pc_o, 32'h80);
    step();

    repeat (20) begin
      drive(1, 32'h200, 1, 32'h200, 1, 32'h300, 0, '0, 0);
      step();
    end
    chk("sat_mc", 32'(mispred_cnt_o), 32'hF);
    drive(1, 32'h200, 1, 32'h200, 0, '0, 1, 32'h300, 1);
    step();
    chk("clr_mc", 32'(mispred_cnt_o), 32'd0);

    look(1, 32'hFFFF_FFFC);
    #1;
    chk("wrap_next", pred_next_pc_o, 32'h0);
    step();

    drive(1, 32'h140, 1, 32'h180, 1, 32'h20, 0, '0, 0);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_hit", 32'(hit_o), 32'd0);
    chk("arst_next", pred_next_pc_o, 32'h144);
    chk("arst_bc", 32'(branch_cnt_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    look(1, 32'h180);
    #1;
    chk("post_rst_miss", 32'(hit_o), 32'd0);
    step();

    repeat (400) begin
      pc  = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2)
            | $urandom_range(0, 3);
      upc = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2)
            | $urandom_range(0, 3);
      tg  = $urandom_range(0, 3) << 4;
      drive($urandom_range(0, 3) != 0, pc,
            $urandom_range(0, 3) != 0, upc,
            $urandom_range(0, 1) == 1, tg,
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? tg : 32'h10,
            $urandom_range(0, 31) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
